// File: rtl/nand_cell_arbiter.sv
// Round-robin sequencer sharing one external 2-input NAND cell among NREQ requesters.
// Latency: rsp_valid rises on edge T+SETTLE_CYC+1, where T is the transfer edge; one transaction per SETTLE_CYC+2 cycles.
// Backpressure: req_ready is 0 while busy, and pending requests are arbitrated at the next IDLE; responses cannot be stalled.
// Optional feature: define NAND_XCHK_EN to flag an X/Z cell output through rsp_err.
module nand_cell_arbiter #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] rsp_valid,
    output logic            rsp_f,
    output logic            rsp_err,
    output logic            busy,
    output logic            cell_a,
    output logic            cell_b,
    input  logic            cell_f
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    // A zero settle time would sample the cell in the same cycle its operands change.
    if (SETTLE_CYC < 1) begin : g_settle_chk
        $error("nand_cell_arbiter: SETTLE_CYC must be >= 1");
    end
    if (NREQ < 2) begin : g_nreq_chk
        $error("nand_cell_arbiter: NREQ must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   gsel;
    logic            found;
    logic [PW-1:0]   idx;
    logic [SW-1:0]   sum;

    assign busy = (state != IDLE);

    // Round-robin pick: first requester at or after ptr, wrapping; silent outside IDLE and during reset.
    always_comb begin
        req_ready = '0;
        gsel      = '0;
        found     = 1'b0;
        idx       = '0;
        sum       = '0;
        if (state == IDLE && !rst) begin
            for (int i = 0; i < NREQ; i++) begin
                sum = {1'b0, ptr} + SW'(i);
                if (sum >= SW'(NREQ)) begin
                    sum = sum - SW'(NREQ);
                end
                idx = sum[PW-1:0];
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    req_ready[idx] = 1'b1;
                    gsel           = idx;
                end
            end
        end
    end

    // Transaction sequencer: latch operands, hold them for SETTLE_CYC cycles, then sample and return the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt_idx   <= '0;
            rsp_valid <= '0;
            rsp_f     <= 1'b0;
            rsp_err   <= 1'b0;
            cell_a    <= 1'b0;
            cell_b    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_f     <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        cell_a  <= req_a[gsel];
                        cell_b  <= req_b[gsel];
                        gnt_idx <= gsel;
                        cnt     <= CW'(SETTLE_CYC - 1);
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_valid[gnt_idx] <= 1'b1;
`ifdef NAND_XCHK_EN
                    if (cell_f === 1'bx || cell_f === 1'bz) begin
                        rsp_err <= 1'b1;
                        rsp_f   <= 1'b0;
                    end else begin
                        rsp_err <= 1'b0;
                        rsp_f   <= cell_f;
                    end
`else
                    rsp_f <= cell_f;
`endif
                    // The requester just served drops to lowest priority.
                    ptr   <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
